// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings.
package shifter_pkg;

  localparam int SHIFT_OP_W = 2;

  localparam logic [SHIFT_OP_W-1:0] SHIFT_OP_SLL = 2'b00;
  localparam logic [SHIFT_OP_W-1:0] SHIFT_OP_SRL = 2'b01;
  localparam logic [SHIFT_OP_W-1:0] SHIFT_OP_SRA = 2'b10;
  localparam logic [SHIFT_OP_W-1:0] SHIFT_OP_ROL = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One log-shifter stage: conditional shift/rotate by DIST, plus the payload
// register and valid flag that hold while the downstream slot is blocked.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST = 1,
  parameter int TAG_W = 5,
  localparam int SHAMT_W = $clog2(WIDTH),
  localparam int BIT = $clog2(DIST)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  up_valid,
  input  logic [WIDTH-1:0]      up_data,
  input  logic [SHAMT_W-1:0]    up_shamt,
  input  logic [SHIFT_OP_W-1:0] up_op,
  input  logic                  up_fill,
  input  logic [TAG_W-1:0]      up_tag,
  output logic                  valid,
  output logic [WIDTH-1:0]      data,
  output logic [SHAMT_W-1:0]    shamt,
  output logic [SHIFT_OP_W-1:0] op,
  output logic                  fill,
  output logic [TAG_W-1:0]      tag
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = up_data;
    if (up_shamt[BIT]) begin
      case (up_op)
        SHIFT_OP_SLL: shifted = up_data << DIST;
        SHIFT_OP_SRL: shifted = up_data >> DIST;
        SHIFT_OP_SRA: shifted = {{DIST{up_fill}}, up_data[WIDTH-1:DIST]};
        default:      shifted = {up_data[WIDTH-DIST-1:0], up_data[WIDTH-1:WIDTH-DIST]};
      endcase
    end
  end

  // Payload only loads with a real beat, so idle slots never capture X or
  // garbage and a blocked output keeps its data steady.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
      shamt <= '0;
      op    <= '0;
      fill  <= 1'b0;
      tag   <= '0;
    end else if (advance) begin
      valid <= up_valid;
      if (up_valid) begin
        data  <= shifted;
        shamt <= up_shamt;
        op    <= up_op;
        fill  <= up_fill;
        tag   <= up_tag;
      end
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined log-shifter (SLL/SRL/SRA/ROL) with valid/ready back-pressure;
// one register stage per shift-amount bit, tag carried alongside the data.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SHAMT_W-1:0]    in_shamt,
  input  logic [SHIFT_OP_W-1:0] in_op,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [TAG_W-1:0]      out_tag
);

  // Element k is the input of stage k; element SHAMT_W is the block output.
  logic [SHAMT_W:0]        valid_pipe;
  logic [WIDTH-1:0]        data_pipe  [SHAMT_W+1];
  logic [SHAMT_W-1:0]      shamt_pipe [SHAMT_W+1];
  logic [SHIFT_OP_W-1:0]   op_pipe    [SHAMT_W+1];
  logic                    fill_pipe  [SHAMT_W+1];
  logic [TAG_W-1:0]        tag_pipe   [SHAMT_W+1];
  logic [SHAMT_W-1:0]      ready_vec;
  logic                    chain;

  assign valid_pipe[0] = in_valid;
  assign data_pipe[0]  = in_data;
  assign shamt_pipe[0] = in_shamt;
  assign op_pipe[0]    = in_op;
  assign fill_pipe[0]  = in_data[WIDTH-1];
  assign tag_pipe[0]   = in_tag;

  // ready_k = !valid_k || ready_{k+1}, unrolled from the output end so the
  // chain only depends on registered valids.
  always_comb begin
    chain     = out_ready;
    ready_vec = '0;
    for (int k = SHAMT_W - 1; k >= 0; k--) begin
      chain        = !valid_pipe[k+1] || chain;
      ready_vec[k] = chain;
    end
  end

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .DIST  (1 << k),
      .TAG_W (TAG_W)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .advance  (ready_vec[k]),
      .up_valid (valid_pipe[k]),
      .up_data  (data_pipe[k]),
      .up_shamt (shamt_pipe[k]),
      .up_op    (op_pipe[k]),
      .up_fill  (fill_pipe[k]),
      .up_tag   (tag_pipe[k]),
      .valid    (valid_pipe[k+1]),
      .data     (data_pipe[k+1]),
      .shamt    (shamt_pipe[k+1]),
      .op       (op_pipe[k+1]),
      .fill     (fill_pipe[k+1]),
      .tag      (tag_pipe[k+1])
    );
  end

  assign in_ready  = ready_vec[0];
  assign out_valid = valid_pipe[SHAMT_W];
  assign out_data  = data_pipe[SHAMT_W];
  assign out_tag   = tag_pipe[SHAMT_W];

  logic unused_tail;
  assign unused_tail = ^{shamt_pipe[SHAMT_W], op_pipe[SHAMT_W], fill_pipe[SHAMT_W]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed cases plus a random stream
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_pipelined_barrel_shifter;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int LAT   = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [4:0]       in_shamt;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    int               acc;
  } beat_t;

  beat_t       sb[$];
  int          n_compared = 0;
  int          n_mismatched = 0;
  int          cyc = 0;
  int          n_in = 0;
  int          n_out = 0;
  int          last_lat = 0;
  bit          check_lat = 1'b0;
  bit          delivered_now = 1'b0;
  bit          prev_stall = 1'b0;
  logic [63:0] prev_out = '0;
  logic [WIDTH-1:0] last_data = '0;
  logic [TAG_W-1:0] last_tag = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] op, input logic [WIDTH-1:0] d,
                                                 input int s);
    case (op)
      2'd0:    return d << s;
      2'd1:    return d >> s;
      2'd2:    return WIDTH'($signed(d) >>> s);
      default: return (s == 0) ? d : ((d << s) | (d >> (WIDTH - s)));
    endcase
  endfunction

  // One cycle: sample #1 after the falling edge (inputs already set), update
  // the scoreboard, then advance to the next falling edge.
  task automatic step();
    beat_t b;
    #1;
    delivered_now = 1'b0;
    if (out_valid && out_ready) begin
      delivered_now = 1'b1;
      last_data = out_data;
      last_tag = out_tag;
      n_out++;
      if (sb.size() == 0) begin
        check("stale_beat", 64'(sb.size()), 64'd1);
      end else begin
        b = sb.pop_front();
        check("sb_data", out_data, b.data);
        check("sb_tag", out_tag, b.tag);
        last_lat = cyc - b.acc;
        if (check_lat) check("latency", 64'(last_lat), 64'(LAT));
      end
    end
    if (out_valid && !out_ready) begin
      if (prev_stall) check("stall_stable", {27'd0, out_tag, out_data}, prev_out);
      prev_stall = 1'b1;
      prev_out = {27'd0, out_tag, out_data};
    end else begin
      prev_stall = 1'b0;
    end
    if (in_valid && in_ready) begin
      sb.push_back('{ref_shift(in_op, in_data, int'(in_shamt)), in_tag, cyc});
      n_in++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_beat(input logic [1:0] op, input logic [WIDTH-1:0] d, input int s,
                          input logic [TAG_W-1:0] t);
    in_valid = 1'b1;
    in_op = op;
    in_data = d;
    in_shamt = 5'(s);
    in_tag = t;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_op = 2'($urandom);
    in_data = $urandom;
    in_shamt = 5'($urandom);
    in_tag = 5'($urandom);
  endtask

  task automatic run_until_delivered(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      step();
      if (delivered_now) return;
    end
    check({tag, "_timeout"}, 64'(delivered_now), 64'd1);
  endtask

  task automatic directed(input string name, input logic [1:0] op, input logic [WIDTH-1:0] d,
                          input int s, input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] exp);
    set_beat(op, d, s, t);
    step();
    idle();
    run_until_delivered(name, 20);
    check(name, last_data, exp);
    check({name, "_tag"}, last_tag, t);
    check({name, "_lat"}, 64'(last_lat), 64'(LAT));
  endtask

  task automatic drain(input string name, input int max);
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < max && sb.size() > 0; i++) step();
    for (int i = 0; i < 2; i++) step();
    check({name, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_in, base_out, guard;
    reset = 1'b0;
    out_ready = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    reset = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // directed single beats, unstalled
    check_lat = 1'b1;
    directed("sll31", 2'd0, 32'h0000_0001, 31, 5'd3, 32'h8000_0000);
    directed("sra4", 2'd2, 32'h8000_0000, 4, 5'd7, 32'hF800_0000);
    directed("srl4", 2'd1, 32'h8000_0000, 4, 5'd8, 32'h0800_0000);
    directed("rol1", 2'd3, 32'h8000_0001, 1, 5'd9, 32'h0000_0003);
    directed("sra0", 2'd2, 32'h8765_4321, 0, 5'd1, 32'h8765_4321);
    directed("rol31", 2'd3, 32'h0000_0001, 31, 5'd2, 32'h8000_0000);

    // back-to-back stream, all ops, shamt 0..15
    for (int i = 0; i < 16; i++) begin
      set_beat(2'(i % 4), $urandom, i, 5'(i));
      check("stream_in_ready", 64'(in_ready), 64'd1);
      step();
    end
    drain("stream", 20);

    // stall with continuous input: capacity and stable output
    check_lat = 1'b0;
    out_ready = 1'b0;
    base_in = n_in;
    for (int i = 0; i < 10; i++) begin
      set_beat(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 31), 5'($urandom));
      step();
    end
    check("stall_accepted", 64'(n_in - base_in), 64'd5);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    base_out = n_out;
    drain("stall", 20);
    check("stall_delivered", 64'(n_out - base_out), 64'd5);

    // reset with beats in flight and output blocked
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_beat(2'd0, $urandom, i, 5'(i));
      step();
    end
    idle();
    step();
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", out_data, 0);
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    base_out = n_out;
    for (int i = 0; i < 8; i++) step();
    check("midrst_no_stale", 64'(n_out - base_out), 64'd0);
    check_lat = 1'b1;
    directed("post_rst_srl0", 2'd1, 32'hFFFF_FFFF, 0, 5'd4, 32'hFFFF_FFFF);

    // random stream with random back-pressure
    check_lat = 1'b0;
    base_in = n_in;
    base_out = n_out;
    guard = 0;
    while ((n_in - base_in) < 10000 && guard < 60000) begin
      if ($urandom_range(0, 3) != 0)
        set_beat(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 31), 5'($urandom));
      else
        idle();
      out_ready = ($urandom_range(0, 9) < 7);
      step();
      guard++;
    end
    check("rand_beats_in", 64'(n_in - base_in), 64'd10000);
    drain("rand", 50);
    check("rand_count", 64'(n_out - base_out), 64'(n_in - base_in));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
